// File: rtl/rec_seq_tx.sv
// rec_seq_tx: serial frame transmitter feeding the sequence recognizer X input.
// Each accepted word becomes one frame: PREAMBLE (MSB first), DIN (MSB first),
// an optional even-parity bit, then GAP_CYC forced-zero cycles.
//
// state  | meaning
// IDLE   | X=0, ready for a word
// PRE    | shifting out the preamble
// DATA   | shifting out the captured payload
// PAR    | one cycle of even parity over the payload
// GAP    | forced-zero cycles closing the frame
//
// Ports:
//   CK         clock, rising edge
//   RESET      synchronous active-high reset
//   DIN        payload word
//   DIN_VALID  payload word valid
//   DIN_READY  transmitter can accept a word (IDLE)
//   X          registered serial output
//   BUSY       frame in progress (PRE/DATA/PAR/GAP)
//   DONE       one-cycle pulse on the first IDLE cycle after a frame
module rec_seq_tx #(
  parameter int                 DATA_W    = 8,
  parameter int                 PRE_W     = 4,
  parameter logic [PRE_W-1:0]   PREAMBLE  = 4'b1010,
  parameter int                 PARITY_EN = 1,
  parameter int                 GAP_CYC   = 2
) (
  input  logic              CK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              X,
  output logic              BUSY,
  output logic              DONE
);

  localparam int M1    = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int M2    = (M1 > GAP_CYC) ? M1 : GAP_CYC;
  localparam int M3    = (M2 > 1) ? M2 : 1;
  localparam int CNT_W = $clog2(M3) + 1;

  localparam logic [CNT_W-1:0] C_PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_PAR  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic                r_x;
  logic                r_done;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_par_nxt;
  logic                w_x_nxt;
  logic                w_done_nxt;
  logic                w_pre_bit;

  always_ff @(posedge CK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_x     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_x     <= w_x_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    case (r_state)
      S_IDLE: begin
        if (DIN_VALID) begin
          w_state_nxt = S_PRE;
          w_cnt_nxt   = C_PRE_LAST;
          w_shift_nxt = DIN;
          w_par_nxt   = ^DIN;
        end
      end
      S_PRE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = C_DATA_LAST;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = '0;
          if (PARITY_EN != 0) begin
            w_state_nxt = S_PAR;
          end else if (GAP_CYC > 0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = C_GAP_LAST;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
          w_shift_nxt = r_shift << 1;
        end
      end
      S_PAR: begin
        w_cnt_nxt = '0;
        if (GAP_CYC > 0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = C_GAP_LAST;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // X is registered, so the flop is loaded with the bit belonging to the
  // state/count that becomes current on this edge.
  assign w_pre_bit = |(PREAMBLE & (PRE_W'(1) << w_cnt_nxt));

  always_comb begin
    w_x_nxt = 1'b0;
    case (w_state_nxt)
      S_PRE:   w_x_nxt = w_pre_bit;
      S_DATA:  w_x_nxt = w_shift_nxt[DATA_W-1];
      S_PAR:   w_x_nxt = w_par_nxt;
      default: w_x_nxt = 1'b0;
    endcase
  end

  assign w_done_nxt = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

  assign X         = r_x;
  assign BUSY      = (r_state != S_IDLE);
  assign DIN_READY = (r_state == S_IDLE);
  assign DONE      = r_done;

endmodule

// File: tb/tb_rec_seq_tx.sv
module tb_rec_seq_tx;

  localparam int DW0 = 8, PAR0 = 1, GAP0 = 2;
  localparam int DW1 = 4, PAR1 = 0, GAP1 = 0;
  localparam int PW  = 4;

  logic       CK = 1'b0;
  logic       RESET;
  logic [7:0] din0;
  logic [3:0] din1;
  logic       v0, v1;
  logic       rdy0, x0, busy0, done0;
  logic       rdy1, x1, busy1, done1;

  always #5 CK = ~CK;

  rec_seq_tx #(.DATA_W(DW0), .PRE_W(PW), .PREAMBLE(4'b1010), .PARITY_EN(PAR0), .GAP_CYC(GAP0)) u_dut0 (
    .CK(CK), .RESET(RESET), .DIN(din0), .DIN_VALID(v0),
    .DIN_READY(rdy0), .X(x0), .BUSY(busy0), .DONE(done0)
  );

  rec_seq_tx #(.DATA_W(DW1), .PRE_W(PW), .PREAMBLE(4'b1010), .PARITY_EN(PAR1), .GAP_CYC(GAP1)) u_dut1 (
    .CK(CK), .RESET(RESET), .DIN(din1), .DIN_VALID(v1),
    .DIN_READY(rdy1), .X(x1), .BUSY(busy1), .DONE(done1)
  );

  typedef struct packed {
    logic x;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;
  logic [3:0] pre_pat = 4'b1010;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int flen(input int sel);
    if (sel == 0) return PW + DW0 + PAR0 + GAP0;
    return PW + DW1 + PAR1 + GAP1;
  endfunction

  // Reference frame: one entry per cycle after the handshake edge, ending
  // with the DONE cycle in IDLE.
  task automatic push_frame(input int sel, input logic [7:0] data);
    int   dw, pe, gp;
    logic p;
    exp_t e;
    dw = (sel == 0) ? DW0 : DW1;
    pe = (sel == 0) ? PAR0 : PAR1;
    gp = (sel == 0) ? GAP0 : GAP1;
    p  = 1'b0;
    e.busy = 1'b1; e.ready = 1'b0; e.done = 1'b0;
    for (int i = PW - 1; i >= 0; i--) begin
      e.x = pre_pat[i];
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    for (int i = dw - 1; i >= 0; i--) begin
      e.x = data[i];
      p   = p ^ data[i];
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (pe != 0) begin
      e.x = p;
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    for (int i = 0; i < gp; i++) begin
      e.x = 1'b0;
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end
    e = '{x: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b1};
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic send_word(input int sel, input logic [7:0] data);
    if (sel == 0) begin din0 = data; v0 = 1'b1; end
    else begin din1 = data[3:0]; v1 = 1'b1; end
    @(posedge CK);
    #1;
    push_frame(sel, data);
  endtask

  task automatic wait_frame(input int sel, input bit junk, input bit hold);
    repeat (flen(sel)) begin
      @(posedge CK);
      #1;
      if (junk && !hold) begin
        if (sel == 0) begin din0 = 8'($urandom); v0 = 1'($urandom); end
        else begin din1 = 4'($urandom); v1 = 1'($urandom); end
      end
    end
    if (!hold) begin
      if (sel == 0) v0 = 1'b0; else v1 = 1'b0;
    end
  endtask

  always @(negedge CK) begin
    if (mon_en) begin
      if (q0.size() > 0) e0 = q0.pop_front();
      else e0 = '{x: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0};
      if (q1.size() > 0) e1 = q1.pop_front();
      else e1 = '{x: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0};
      chk("d0_x",     32'(x0),    32'(e0.x));
      chk("d0_busy",  32'(busy0), 32'(e0.busy));
      chk("d0_ready", 32'(rdy0),  32'(e0.ready));
      chk("d0_done",  32'(done0), 32'(e0.done));
      chk("d1_x",     32'(x1),    32'(e1.x));
      chk("d1_busy",  32'(busy1), 32'(e1.busy));
      chk("d1_ready", 32'(rdy1),  32'(e1.ready));
      chk("d1_done",  32'(done1), 32'(e1.done));
    end
  end

  initial begin
    RESET = 1'b1;
    din0  = '0;
    din1  = '0;
    v0    = 1'b0;
    v1    = 1'b0;
    step(1);
    mon_en = 1'b1;
    step(1);
    RESET = 1'b0;
    step(2);

    // single frame, even parity, DIN churn while busy
    send_word(0, 8'hA5);
    wait_frame(0, 1'b1, 1'b0);
    step(2);

    // odd-parity payload
    send_word(0, 8'h01);
    wait_frame(0, 1'b0, 1'b0);
    step(2);

    // back-to-back with DIN_VALID held
    send_word(0, 8'h3C);
    wait_frame(0, 1'b0, 1'b1);
    send_word(0, 8'hC3);
    wait_frame(0, 1'b0, 1'b0);
    step(2);

    // reset while the third data bit is on X
    send_word(0, 8'h96);
    v0 = 1'b0;
    step(6);
    RESET = 1'b1;
    step(1);
    q0.delete();
    RESET = 1'b0;
    step(2);
    send_word(0, 8'h5A);
    v0 = 1'b0;
    wait_frame(0, 1'b0, 1'b0);
    step(2);

    // reset wins over a simultaneous handshake request
    RESET = 1'b1;
    v0    = 1'b1;
    din0  = 8'hFF;
    step(1);
    RESET = 1'b0;
    v0    = 1'b0;
    step(3);

    // no parity, no gap, 4-bit payload
    send_word(1, 8'h09);
    wait_frame(1, 1'b1, 1'b0);
    step(2);
    send_word(1, 8'h06);
    wait_frame(1, 1'b1, 1'b0);
    step(3);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
